// File: rtl/fixp2fp_lane_arbiter.sv
// Shares one fixpkt2fp64 converter between NUM_REQ accumulator lanes.
// Round-robin issue onto the converter, in-order tag FIFO of issuing lanes,
// and steering of each fp64 result back to the lane that issued it.
module fixp2fp_lane_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned IN_WIDTH        = 261,
    parameter int unsigned OUT_WIDTH       = 64,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ-1:0]                   req_tvalid,
    input  logic [NUM_REQ*IN_WIDTH-1:0]          req_tdata,
    output logic [NUM_REQ-1:0]                   req_tready,
    output logic                                 conv_in_tvalid,
    output logic [IN_WIDTH-1:0]                  conv_in_tdata,
    input  logic                                 conv_in_tready,
    input  logic                                 conv_out_tvalid,
    input  logic [OUT_WIDTH-1:0]                 conv_out_tdata,
    output logic                                 conv_out_tready,
    output logic [NUM_REQ-1:0]                   res_tvalid,
    output logic [NUM_REQ*OUT_WIDTH-1:0]         res_tdata,
    input  logic [NUM_REQ-1:0]                   res_tready,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_orphan
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HOLD = 1'b1
    } lock_state_t;

    lock_state_t      lock_state;
    logic [IDX_W-1:0] lock_id;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_grant;
    logic [IDX_W-1:0] rr_cand;
    logic             rr_found;
    logic [IDX_W-1:0] grant;

    logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head;
    logic             fifo_empty;
    logic             can_issue;
    logic             push;
    logic             pop;

    // Issue is allowed only on the registered count; a same-cycle pop frees nothing yet
    assign can_issue  = (count < CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // Round-robin search starting at rr_ptr for the first requesting lane
    always_comb begin
        rr_grant = rr_ptr;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!rr_found && req_tvalid[rr_cand]) begin
                rr_grant = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // A stalled offer keeps its lane until accepted so the converter sees stable data
    assign grant = (lock_state == LOCK_HOLD) ? lock_id : rr_grant;

    // Converter input valid, gated low while in reset
    assign conv_in_tvalid = rstn & can_issue & req_tvalid[grant];
    assign push           = conv_in_tvalid & conv_in_tready;

    // Packet mux from the granted lane
    always_comb begin
        conv_in_tdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                conv_in_tdata = req_tdata[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Only the granted lane sees ready, and only when the converter can take it
    always_comb begin
        req_tready = '0;
        if (rstn && can_issue && conv_in_tready) begin
            req_tready[grant] = 1'b1;
        end
    end

    // Result steering to the lane at the head of the tag FIFO
    always_comb begin
        res_tvalid = '0;
        if (rstn && conv_out_tvalid && !fifo_empty) begin
            res_tvalid[head] = 1'b1;
        end
    end

    assign conv_out_tready = rstn & !fifo_empty & res_tready[head];
    assign pop             = conv_out_tvalid & conv_out_tready;
    assign res_tdata       = {NUM_REQ{conv_out_tdata}};
    assign outstanding     = count;

    // Lock FSM and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_state <= LOCK_IDLE;
            lock_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            case (lock_state)
                LOCK_IDLE: begin
                    if (conv_in_tvalid && !conv_in_tready) begin
                        lock_state <= LOCK_HOLD;
                        lock_id    <= grant;
                    end
                end
                LOCK_HOLD: begin
                    if (push) begin
                        lock_state <= LOCK_IDLE;
                    end
                end
                default: lock_state <= LOCK_IDLE;
            endcase
            if (push) begin
                rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(grant + 1'b1);
            end
        end
    end

    // Tag storage; contents are meaningless while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    // Tag FIFO pointers and in-flight count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            case ({push, pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a converter result with no issuing lane on record
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_orphan <= 1'b0;
        end else if (conv_out_tvalid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
